// File: rtl/tc141_pulsetx.sv
// tc141_pulsetx: turns single-cycle event strobes into fixed-width level pulses
// separated by a guaranteed low gap, so a slow receiver can edge-detect each
// event. Strobes arriving while a pulse is in flight are counted and replayed.
module tc141_pulsetx #(
    parameter int NHI  = 2,
    parameter int NLO  = 2,
    parameter int PW   = 4,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            pin,
    output logic            dout,
    output logic            busy,
    output logic [CNTW-1:0] pend,
    output logic            ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] PEND_MAX = '1;
    localparam logic [PW-1:0]   HI_LOAD  = PW'(NHI - 1);
    localparam logic [PW-1:0]   LO_LOAD  = PW'(NLO - 1);

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_nx;
    logic            dout_nx;
    logic [CNTW-1:0] pend_nx;
    logic            ovf_nx;

    // Register the phase FSM, the pulse level and the backlog counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            phase <= '0;
            dout  <= 1'b0;
            pend  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            dout  <= dout_nx;
            pend  <= pend_nx;
            ovf   <= ovf_nx;
        end
    end

    // Next-state logic: pulse sequencing plus queueing of strobes that land mid-pulse.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        dout_nx  = dout;
        pend_nx  = pend;
        ovf_nx   = 1'b0;

        case (state)
            IDLE: begin
                dout_nx = 1'b0;
                if (pin || (pend != '0)) begin
                    state_nx = HIGH;
                    dout_nx  = 1'b1;
                    phase_nx = HI_LOAD;
                    // A live strobe starts directly; otherwise consume one queued event.
                    // With both present the strobe takes the queued slot, net zero.
                    if (!pin) begin
                        pend_nx = pend - CNTW'(1);
                    end
                end
            end
            HIGH: begin
                dout_nx = 1'b1;
                if (phase == '0) begin
                    state_nx = LOW;
                    dout_nx  = 1'b0;
                    phase_nx = LO_LOAD;
                end else begin
                    phase_nx = phase - PW'(1);
                end
            end
            LOW: begin
                dout_nx = 1'b0;
                if (phase == '0) begin
                    state_nx = IDLE;
                end else begin
                    phase_nx = phase - PW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                dout_nx  = 1'b0;
                phase_nx = '0;
            end
        endcase

        // Strobes seen while a pulse is in progress go to the backlog, or are lost
        // (flagged by ovf) once the backlog counter is full.
        if ((state != IDLE) && pin) begin
            if (pend == PEND_MAX) begin
                ovf_nx = 1'b1;
            end else begin
                pend_nx = pend + CNTW'(1);
            end
        end
    end

    // busy is decoded purely from registered state so it stays glitch-free.
    assign busy = (state != IDLE) || (pend != '0);

endmodule
